// File: rtl/iomem_sample_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_sample_fifo_pkg
// Description : Register map, bit positions and CTRL layout for the sample FIFO
// Revision    : 1.0 - initial release
// ============================================================================
package iomem_sample_fifo_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int ST_FULL_BIT     = 16;
    localparam int ST_EMPTY_BIT    = 17;
    localparam int ST_UNDERRUN_BIT = 18;

    localparam int CTRL_ENABLE_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT       = 1;
    localparam int CTRL_CLR_UNDERRUN_BIT = 2;
    localparam int CTRL_FLUSH_BIT        = 3;
    localparam int CTRL_THRESH_LSB       = 8;

    typedef struct packed {
        logic [7:0] threshold;
        logic       irq_en;
        logic       enable;
    } ctrl_t;

    function automatic logic [31:0] pack_ctrl(input ctrl_t c);
        return {16'b0, c.threshold, 6'b0, c.irq_en, c.enable};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Single-clock FIFO with registered head read and flush
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_rdata;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage has no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            // A pop of an empty FIFO presents zero rather than stale data
            if (i_pop) begin
                r_rdata <= w_do_pop ? r_mem[r_rd_ptr] : '0;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iomem_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iomem_sample_fifo
// Description : iomem-mapped stereo sample FIFO with underrun flag and refill irq
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_sample_fifo
    import iomem_sample_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        sample_req,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_valid,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_ready;
    logic          r_done;
    logic          r_rd_pending;
    logic [3:0]    r_rd_offset;
    ctrl_t         r_ctrl;
    logic          r_underrun;
    logic          r_irq;
    logic          r_sample_valid;

    logic          w_sel;
    logic [3:0]    w_offset;
    logic          w_push_req;
    logic          w_accept;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_underrun;
    logic          w_pop;
    logic          w_fifo_push;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_count8;
    logic [31:0]   w_fifo_rdata;
    logic [31:0]   w_status;
    logic          w_unused_addr_lsbs;

    assign w_sel      = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_offset   = {iomem_addr[3:2], 2'b00};
    assign w_push_req = w_sel && (w_offset == REG_DATA) && (iomem_wstrb != 4'b0);

    // r_done blocks a second acknowledge while the CPU keeps valid asserted
    // after the first one; a full FIFO stalls the push until space appears.
    assign w_accept       = w_sel && !r_ready && !r_done && !(w_push_req && w_full);
    assign w_ctrl_wr      = w_accept && (w_offset == REG_CTRL) && (iomem_wstrb != 4'b0);
    assign w_flush        = w_ctrl_wr && iomem_wstrb[0] && iomem_wdata[CTRL_FLUSH_BIT];
    assign w_clr_underrun = w_ctrl_wr && iomem_wstrb[0] && iomem_wdata[CTRL_CLR_UNDERRUN_BIT];
    assign w_fifo_push    = w_accept && w_push_req && !w_flush;
    assign w_pop          = sample_req && r_ctrl.enable;
    assign w_count8       = 8'(w_count);

    assign w_unused_addr_lsbs = &{1'b0, iomem_addr[1:0]};

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (iomem_wdata),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready        <= 1'b0;
            r_done         <= 1'b0;
            r_rd_pending   <= 1'b0;
            r_rd_offset    <= '0;
            r_ctrl         <= '0;
            r_underrun     <= 1'b0;
            r_irq          <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_ready        <= w_accept;
            r_done         <= (r_ready || r_done) && iomem_valid;
            r_sample_valid <= w_pop;
            r_irq          <= r_ctrl.irq_en && (w_count8 <= r_ctrl.threshold);
            if (w_accept) begin
                r_rd_pending <= (iomem_wstrb == 4'b0);
                r_rd_offset  <= w_offset;
            end else begin
                r_rd_pending <= 1'b0;
            end
            if (w_ctrl_wr) begin
                if (iomem_wstrb[0]) begin
                    r_ctrl.enable <= iomem_wdata[CTRL_ENABLE_BIT];
                    r_ctrl.irq_en <= iomem_wdata[CTRL_IRQ_EN_BIT];
                end
                if (iomem_wstrb[1]) begin
                    r_ctrl.threshold <= iomem_wdata[CTRL_THRESH_LSB +: 8];
                end
            end
            // A fresh underrun outranks a simultaneous clear
            if (w_pop && w_empty) begin
                r_underrun <= 1'b1;
            end else if (w_clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[7:0]             = w_count8;
        w_status[ST_FULL_BIT]     = w_full;
        w_status[ST_EMPTY_BIT]    = w_empty;
        w_status[ST_UNDERRUN_BIT] = r_underrun;
    end

    // Read data is taken from live state during the acknowledge cycle
    always_comb begin
        iomem_rdata = '0;
        if (r_ready && r_rd_pending) begin
            case (r_rd_offset)
                REG_STATUS: iomem_rdata = w_status;
                REG_CTRL:   iomem_rdata = pack_ctrl(r_ctrl);
                default:    iomem_rdata = '0;
            endcase
        end
    end

    assign iomem_ready  = r_ready;
    assign sample_l     = w_fifo_rdata[31:16];
    assign sample_r     = w_fifo_rdata[15:0];
    assign sample_valid = r_sample_valid;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_iomem_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_sample_fifo
// Description : Scoreboard bench for iomem_sample_fifo (bus, samples, irq)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_sample_fifo;

    localparam logic [31:0] BASE   = 32'h0300_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_RSVD = BASE + 32'hC;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        sample_req;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    bit          m_en       = 1'b0;
    bit          m_underrun = 1'b0;

    iomem_sample_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iomem_valid  (iomem_valid),
        .iomem_ready  (iomem_ready),
        .iomem_wstrb  (iomem_wstrb),
        .iomem_addr   (iomem_addr),
        .iomem_wdata  (iomem_wdata),
        .iomem_rdata  (iomem_rdata),
        .sample_req   (sample_req),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[7:0]  = 8'(mq.size());
        s[16]   = (mq.size() == DEPTH);
        s[17]   = (mq.size() == 0);
        s[18]   = m_underrun;
        return s;
    endfunction

    // Idle cycle, then request held until acknowledged or timed out
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        cyc         = 0;
        rd          = '0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (iomem_ready) break;
        end
        check_eq("bus_ack_seen", 32'(iomem_ready), 32'd1);
        rd          = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
        logic [31:0] rd;
        int          cyc;
        bus_xfer(addr, strb, wd, rd, cyc);
    endtask

    task automatic reg_rd(input logic [31:0] addr, output logic [31:0] rd);
        int cyc;
        bus_xfer(addr, 4'b0, 32'h0, rd, cyc);
    endtask

    task automatic push_word(input logic [31:0] w);
        reg_wr(A_DATA, 4'hF, w);
        mq.push_back(w);
    endtask

    // Expected sample is decided when the request is driven
    task automatic pulse_req();
        sample_req = 1'b1;
        if (m_en) begin
            if (mq.size() > 0) begin
                exp_q.push_back(mq.pop_front());
            end else begin
                exp_q.push_back(32'h0);
                m_underrun = 1'b1;
            end
        end
        @(negedge clk);
        sample_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sample_valid_spurious", 32'(sample_valid), 32'd0);
            end else begin
                check_eq("sample_out", {sample_l, sample_r}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] w17;
        logic [31:0] last_word;
        int          cyc;
        int          acks;

        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        sample_req  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(iomem_ready), 32'd0);
        check_eq("rst_rdata", iomem_rdata, 32'd0);
        check_eq("rst_samples", {sample_l, sample_r}, 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        bus_xfer(A_STAT, 4'b0, 32'h0, rd, cyc);
        check_eq("status_latency", 32'(cyc), 32'd1);
        check_eq("status_reset", rd, 32'h0002_0000);
        reg_rd(A_CTRL, rd);
        check_eq("ctrl_reset", rd, 32'h0);

        reg_wr(A_CTRL, 4'hF, 32'h1);
        m_en = 1'b1;
        reg_rd(A_CTRL, rd);
        check_eq("ctrl_enable", rd, 32'h1);
        push_word(32'h1234_ABCD);
        push_word(32'h0001_FFFF);
        reg_rd(A_DATA, rd);
        check_eq("data_read_zero", rd, 32'h0);
        reg_rd(A_RSVD, rd);
        check_eq("rsvd_read_zero", rd, 32'h0);
        pulse_req();
        @(negedge clk);
        pulse_req();
        @(negedge clk);

        // Fill to DEPTH, then a 17th push must stall until one pop
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        reg_rd(A_STAT, rd);
        check_eq("status_full", rd, exp_status());
        w17 = $urandom;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_DATA;
        iomem_wstrb = 4'hF;
        iomem_wdata = w17;
        repeat (4) begin
            @(negedge clk);
            check_eq("stall_hold", 32'(iomem_ready), 32'd0);
        end
        pulse_req();
        check_eq("stall_after_pop", 32'(iomem_ready), 32'd0);
        @(negedge clk);
        check_eq("stall_ack", 32'(iomem_ready), 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        mq.push_back(w17);
        reg_rd(A_STAT, rd);
        check_eq("status_refull", rd, exp_status());

        last_word = mq[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) pulse_req();
        @(negedge clk);

        // Disabled: request ignored, outputs hold, no underrun
        reg_wr(A_CTRL, 4'hF, 32'h0);
        m_en = 1'b0;
        pulse_req();
        @(negedge clk);
        check_eq("disabled_hold", {sample_l, sample_r}, last_word);
        reg_rd(A_STAT, rd);
        check_eq("disabled_status", rd, exp_status());

        reg_wr(A_CTRL, 4'hF, 32'h1);
        m_en = 1'b1;
        pulse_req();
        @(negedge clk);
        reg_rd(A_STAT, rd);
        check_eq("underrun_set", rd, exp_status());
        reg_wr(A_CTRL, 4'hF, 32'h5);
        m_underrun = 1'b0;
        reg_rd(A_STAT, rd);
        check_eq("underrun_clear", rd, exp_status());

        for (int i = 0; i < 3; i++) push_word($urandom);
        reg_wr(A_CTRL, 4'hF, 32'h9);
        mq.delete();
        reg_rd(A_STAT, rd);
        check_eq("flush_status", rd, exp_status());

        // Refill interrupt at threshold 4
        reg_wr(A_CTRL, 4'hF, 32'h0403);
        for (int i = 0; i < 6; i++) push_word($urandom);
        @(negedge clk);
        check_eq("irq_low_at6", 32'(irq), 32'd0);
        pulse_req();
        @(negedge clk);
        check_eq("irq_low_at5", 32'(irq), 32'd0);
        pulse_req();
        check_eq("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check_eq("irq_rise", 32'(irq), 32'd1);
        push_word($urandom);
        check_eq("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        check_eq("irq_fall", 32'(irq), 32'd0);

        // Held valid on a byte-0-only CTRL write: one acknowledge
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = A_CTRL;
        iomem_wstrb = 4'b0001;
        iomem_wdata = 32'h0000_0003;
        acks        = 0;
        repeat (5) begin
            @(negedge clk);
            if (iomem_ready) acks++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        @(negedge clk);
        if (iomem_ready) acks++;
        check_eq("held_valid_acks", 32'(acks), 32'd1);
        reg_rd(A_CTRL, rd);
        check_eq("ctrl_byte0_only", rd, 32'h0000_0403);
        reg_wr(A_CTRL, 4'b0010, 32'hFFFF_07FF);
        reg_rd(A_CTRL, rd);
        check_eq("ctrl_byte1_only", rd, 32'h0000_0703);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hDEAD_BEEF;
        acks        = 0;
        repeat (6) begin
            @(negedge clk);
            if (iomem_ready) acks++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        check_eq("unmapped_acks", 32'(acks), 32'd0);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
